alu_ctrl_mc: RTL and testbench

Parametrised RV32IM ALU control unit with multi-cycle sequencing. It decodes `alu_op` plus funct3/funct7 into the extended 4-bit ALU operation code for all RV32I ALU ops. It recognises M-extension (mul/div) R-type instructions and runs a counted multi-cycle handshake to the mul/div unit, stalling the pipeline until the result is ready. It sits between the main decoder and the datapath ALU / mul-div unit.

---
 rtl/alu_ctrl_mc.sv | 177 +++++++++++++++++
 tb/tb_alu_ctrl_mc.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_mc.sv
// RV32IM ALU control: single-cycle decode of alu_op/funct3/funct7 into a 4-bit ALU code, plus a
// counted IDLE/BUSY/DONE handshake that stalls the pipeline while the mul/div unit works.
module alu_ctrl_mc #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] instruccion,
  input  logic [1:0]       alu_op,
  input  logic             valid,
  input  logic             flush,
  output logic [3:0]       alu_inst,
  output logic             illegal,
  output logic             md_start,
  output logic [2:0]       md_op,
  output logic             stall,
  output logic             result_valid
);

  localparam int unsigned MaxCycles = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  localparam logic [CntW-1:0] MulLoad = CntW'(MUL_CYCLES - 1);
  localparam logic [CntW-1:0] DivLoad = CntW'(DIV_CYCLES - 1);

  localparam logic [3:0] AluAnd    = 4'b0000;
  localparam logic [3:0] AluOr     = 4'b0001;
  localparam logic [3:0] AluAdd    = 4'b0010;
  localparam logic [3:0] AluXor    = 4'b0011;
  localparam logic [3:0] AluSll    = 4'b0100;
  localparam logic [3:0] AluSrl    = 4'b0101;
  localparam logic [3:0] AluSub    = 4'b0110;
  localparam logic [3:0] AluSra    = 4'b0111;
  localparam logic [3:0] AluSlt    = 4'b1000;
  localparam logic [3:0] AluSltu   = 4'b1001;
  localparam logic [3:0] AluMulDiv = 4'b1100;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;
  localparam logic [6:0] F7MulD = 7'b0000001;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      md_op_q, md_op_d;
  logic            md_start_q;

  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [3:0] dec_inst;
  logic       dec_illegal;
  logic       is_md;
  logic       capture;
  logic       unused_instr;

  assign funct3       = instruccion[14:12];
  assign funct7       = instruccion[31:25];
  assign unused_instr = ^instruccion;

  // Plain funct3 mapping shared by R-type funct7=0000000 and I-type ALU ops.
  function automatic logic [3:0] base_op(input logic [2:0] f3);
    logic [3:0] code;
    unique case (f3)
      3'b000:  code = AluAdd;
      3'b001:  code = AluSll;
      3'b010:  code = AluSlt;
      3'b011:  code = AluSltu;
      3'b100:  code = AluXor;
      3'b101:  code = AluSrl;
      3'b110:  code = AluOr;
      default: code = AluAnd;
    endcase
    return code;
  endfunction

  always_comb begin
    dec_inst    = AluAdd;
    dec_illegal = 1'b0;
    is_md       = 1'b0;
    unique case (alu_op)
      2'b00: dec_inst = AluAdd;
      2'b01: dec_inst = AluSub;
      2'b10: begin
        unique case (funct7)
          F7Base: dec_inst = base_op(funct3);
          F7Alt: begin
            if (funct3 == 3'b000) begin
              dec_inst = AluSub;
            end else if (funct3 == 3'b101) begin
              dec_inst = AluSra;
            end else begin
              dec_illegal = 1'b1;
            end
          end
          F7MulD: begin
            dec_inst = AluMulDiv;
            is_md    = 1'b1;
          end
          default: dec_illegal = 1'b1;
        endcase
      end
      default: begin
        // I-type: the upper immediate bits only matter for the shift encodings.
        if (funct3 == 3'b001) begin
          if (funct7 == F7Base) begin
            dec_inst = AluSll;
          end else begin
            dec_illegal = 1'b1;
          end
        end else if (funct3 == 3'b101) begin
          if (funct7 == F7Base) begin
            dec_inst = AluSrl;
          end else if (funct7 == F7Alt) begin
            dec_inst = AluSra;
          end else begin
            dec_illegal = 1'b1;
          end
        end else begin
          dec_inst = base_op(funct3);
        end
      end
    endcase
  end

  assign capture = (state_q != StBusy) & valid & is_md & ~flush;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    md_op_d = md_op_q;
    unique case (state_q)
      StIdle: state_d = StIdle;
      StBusy: begin
        if (flush) begin
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // capture is only possible outside BUSY, so it overrides IDLE/DONE transitions.
    if (capture) begin
      state_d = StBusy;
      md_op_d = funct3;
      cnt_d   = funct3[2] ? DivLoad : MulLoad;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      md_op_q    <= 3'b000;
      md_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      md_op_q    <= md_op_d;
      md_start_q <= capture;
    end
  end

  assign alu_inst     = (state_q == StIdle) ? dec_inst : AluMulDiv;
  assign illegal      = valid & dec_illegal;
  assign md_start     = md_start_q;
  assign md_op        = md_op_q;
  assign stall        = capture | (state_q == StBusy);
  assign result_valid = (state_q == StDone);

endmodule

// File: tb/tb_alu_ctrl_mc.sv
// Bench for alu_ctrl_mc: directed and random steps checked against a timeline model that tracks
// each mul/div transaction by its capture cycle and latency.
module tb_alu_ctrl_mc;

  localparam int MulN = 2;
  localparam int DivN = 32;
  localparam logic [31:0] BaseTab = {4'b0000, 4'b0001, 4'b0101, 4'b0011,
                                     4'b1001, 4'b1000, 4'b0100, 4'b0010};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instruccion;
  logic [1:0]  alu_op;
  logic        valid;
  logic        flush;
  logic [3:0]  alu_inst;
  logic        illegal;
  logic        md_start;
  logic [2:0]  md_op;
  logic        stall;
  logic        result_valid;

  int tests = 0;
  int fails = 0;

  // Transaction timeline model.
  int         cyc = 0;
  bit         m_active = 1'b0;
  int         m_t0 = 0;
  int         m_n = 0;
  logic [2:0] m_op = 3'b000;

  alu_ctrl_mc #(
    .WIDTH     (32),
    .MUL_CYCLES(MulN),
    .DIV_CYCLES(DivN)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instruccion (instruccion),
    .alu_op      (alu_op),
    .valid       (valid),
    .flush       (flush),
    .alu_inst    (alu_inst),
    .illegal     (illegal),
    .md_start    (md_start),
    .md_op       (md_op),
    .stall       (stall),
    .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns {illegal, is_md, code}.
  function automatic logic [5:0] ref_dec(input logic [1:0] op, input logic [31:0] ins);
    logic [2:0] f3;
    logic [6:0] f7;
    logic [3:0] base;
    f3   = ins[14:12];
    f7   = ins[31:25];
    base = BaseTab[int'(f3)*4 +: 4];
    if (op == 2'b00) return {2'b00, 4'b0010};
    if (op == 2'b01) return {2'b00, 4'b0110};
    if (op == 2'b10) begin
      if (f7 == 7'h00) return {2'b00, base};
      if (f7 == 7'h20) begin
        if (f3 == 3'd0) return {2'b00, 4'b0110};
        if (f3 == 3'd5) return {2'b00, 4'b0111};
        return {2'b10, 4'b0010};
      end
      if (f7 == 7'h01) return {2'b01, 4'b1100};
      return {2'b10, 4'b0010};
    end
    if (f3 == 3'd1 && f7 != 7'h00) return {2'b10, 4'b0010};
    if (f3 == 3'd5) begin
      if (f7 == 7'h00) return {2'b00, 4'b0101};
      if (f7 == 7'h20) return {2'b00, 4'b0111};
      return {2'b10, 4'b0010};
    end
    return {2'b00, base};
  endfunction

  function automatic logic [31:0] instr(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 10'($urandom), f3, 12'($urandom)};
  endfunction

  task automatic step(input logic v, input logic [1:0] op, input logic [31:0] ins,
                      input logic fl);
    logic [5:0] d;
    logic in_busy, in_done, cap;
    @(negedge clk);
    valid = v; alu_op = op; instruccion = ins; flush = fl;
    #1;
    d       = ref_dec(op, ins);
    in_busy = m_active && cyc >= m_t0 + 1 && cyc <= m_t0 + m_n;
    in_done = m_active && cyc == m_t0 + m_n + 1;
    cap     = !in_busy && v && d[4] && !fl;
    check("stall", 32'(stall), 32'(in_busy || cap));
    check("result_valid", 32'(result_valid), 32'(in_done));
    check("md_start", 32'(md_start), 32'(m_active && cyc == m_t0 + 1));
    check("alu_inst", 32'(alu_inst), 32'((in_busy || in_done) ? 4'b1100 : d[3:0]));
    check("illegal", 32'(illegal), 32'(v && d[5]));
    check("md_op", 32'(md_op), 32'(m_op));
    if (in_busy && fl) m_active = 1'b0;
    if (cap) begin
      m_active = 1'b1;
      m_t0     = cyc;
      m_n      = ins[14] ? DivN : MulN;
      m_op     = ins[14:12];
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, $urandom, 1'b0);
  endtask

  // Asserts rst_n between clock edges, mid-transaction if one is running.
  task automatic async_reset();
    logic in_busy;
    @(negedge clk);
    valid = 1'b0; flush = 1'b0;
    in_busy = m_active && cyc >= m_t0 + 1 && cyc <= m_t0 + m_n;
    #1;
    check("stall_pre_rst", 32'(stall), 32'(in_busy));
    check("md_start_pre_rst", 32'(md_start), 32'(m_active && cyc == m_t0 + 1));
    #1 rst_n = 1'b0;
    #1;
    check("stall_rst", 32'(stall), 32'd0);
    check("md_start_rst", 32'(md_start), 32'd0);
    check("result_valid_rst", 32'(result_valid), 32'd0);
    check("md_op_rst", 32'(md_op), 32'd0);
    m_active = 1'b0;
    m_op     = 3'b000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [1:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    int         r;

    rst_n = 1'b0; valid = 1'b0; flush = 1'b0; alu_op = 2'b00; instruccion = 32'h0;
    #2;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_alu_inst", 32'(alu_inst), 32'h2);
    check("rst_md_start", 32'(md_start), 32'd0);
    check("rst_result_valid", 32'(result_valid), 32'd0);
    check("rst_md_op", 32'(md_op), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Decode sweep.
    for (int i = 0; i < 8; i++) step(1'b1, 2'b10, instr(7'h00, 3'(i)), 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 2'b10, instr(7'h20, 3'(i)), 1'b0);
    step(1'b1, 2'b11, instr(7'h20, 3'b000), 1'b0);
    step(1'b1, 2'b11, instr(7'h00, 3'b101), 1'b0);
    step(1'b1, 2'b11, instr(7'h20, 3'b101), 1'b0);
    step(1'b1, 2'b11, instr(7'h00, 3'b001), 1'b0);
    step(1'b1, 2'b00, $urandom, 1'b0);
    step(1'b1, 2'b01, $urandom, 1'b0);
    step(1'b1, 2'b10, instr(7'h10, 3'b000), 1'b0);
    step(1'b0, 2'b10, instr(7'h20, 3'b111), 1'b0);

    // MUL, then DIV with changing instructions while busy.
    step(1'b1, 2'b10, instr(7'h01, 3'b000), 1'b0);
    idle(4);
    step(1'b1, 2'b10, instr(7'h01, 3'b100), 1'b0);
    for (int i = 0; i < 34; i++) step(1'b1, 2'($urandom), $urandom, 1'b0);
    idle(36);

    // Back-to-back: REM presented in the DONE cycle of a MUL.
    step(1'b1, 2'b10, instr(7'h01, 3'b000), 1'b0);
    idle(2);
    step(1'b1, 2'b10, instr(7'h01, 3'b110), 1'b0);
    idle(36);

    // Flush in the 5th BUSY cycle of a DIV, then flush coincident with a capture.
    step(1'b1, 2'b10, instr(7'h01, 3'b101), 1'b0);
    idle(4);
    step(1'b0, 2'b00, $urandom, 1'b1);
    idle(3);
    step(1'b1, 2'b10, instr(7'h01, 3'b000), 1'b1);
    idle(2);

    // Asynchronous reset mid-DIV, then a normal MUL.
    step(1'b1, 2'b10, instr(7'h01, 3'b100), 1'b0);
    async_reset();
    step(1'b1, 2'b10, instr(7'h01, 3'b111), 1'b0);
    idle(9);
    async_reset();
    step(1'b1, 2'b10, instr(7'h01, 3'b001), 1'b0);
    idle(4);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      op = 2'($urandom_range(0, 3));
      f3 = 3'($urandom);
      r  = $urandom_range(0, 9);
      if (r < 4)      f7 = 7'h00;
      else if (r < 6) f7 = 7'h20;
      else if (r < 9) f7 = 7'h01;
      else            f7 = 7'($urandom);
      if (op == 2'b11) begin
        if (f3 == 3'd1)      f7 = 7'h00;
        else if (f3 == 3'd5) f7 = (r < 5) ? 7'h00 : 7'h20;
        else                 f7 = 7'($urandom);
      end
      step($urandom_range(0, 3) != 0, op, instr(f7, f3), $urandom_range(0, 19) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
